// File: rtl/prio_pkg.sv
// Shared definitions for the 16-bit priority encoder and its pending-event scheduler.
package prio_pkg;

    localparam int N_REQ  = 16;
    localparam int IDX_W  = 4;
    localparam int CODE_W = 8;

    // Encoder output meaning "no input bit set".
    localparam logic [CODE_W-1:0] NONE_CODE = 8'hF0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        OFFER  = 2'd2
    } state_t;

endpackage

// File: rtl/prio_pending_scheduler_if.sv
// Event/encoder/grant bundle between the scheduler and its surroundings.
interface prio_pending_scheduler_if #(
    parameter int DROP_W = 8
);
    import prio_pkg::*;

    logic                   ena;
    logic [N_REQ-1:0]       req_in;
    logic [N_REQ-1:0]       pend_out;
    logic [CODE_W-1:0]      enc_code;
    logic                   grant_valid;
    logic                   grant_ready;
    logic [IDX_W-1:0]       grant_idx;
    logic [DROP_W-1:0]      drop_count;
    logic                   err;
    logic                   busy;

    // Environment side: raises events, hosts the encoder, consumes grants.
    modport master (
        output ena, req_in, enc_code, grant_ready,
        input  pend_out, grant_valid, grant_idx, drop_count, err, busy
    );

    // Scheduler side.
    modport slave (
        input  ena, req_in, enc_code, grant_ready,
        output pend_out, grant_valid, grant_idx, drop_count, err, busy
    );

endinterface

// File: rtl/prio_popcount16.sv
// Combinational population count of a 16-bit vector.
module prio_popcount16
    import prio_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    output logic [4:0]       count
);

    // Sum the individual bits; 16 ones fit in 5 bits.
    always_comb begin
        count = '0;
        for (int i = 0; i < N_REQ; i++) begin
            count = count + {4'b0000, vec[i]};
        end
    end

endmodule

// File: rtl/prio_pending_scheduler.sv
// Sticky pending-event register feeding a priority encoder, with a grant
// handshake for the encoder's winner, saturating drop counter and encoder
// consistency checking.
module prio_pending_scheduler
    import prio_pkg::*;
#(
    parameter int DROP_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    prio_pending_scheduler_if.slave   bus
);

    state_t             state_q;
    state_t             state_d;
    logic [N_REQ-1:0]   pend_q;
    logic [N_REQ-1:0]   pend_d;
    logic [N_REQ-1:0]   set_vec;
    logic [N_REQ-1:0]   clr_vec;
    logic [N_REQ-1:0]   drop_vec;
    logic [4:0]         drop_n;
    logic [DROP_W-1:0]  drop_q;
    logic [IDX_W-1:0]   idx_q;
    logic               err_q;
    logic               accept;
    logic               code_ok;

    // Add a small increment to the drop counter, pinning at all-ones.
    function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                  input logic [4:0]        b);
        logic [DROP_W+4:0] sum;
        sum = {5'b00000, a} + {{DROP_W{1'b0}}, b};
        if (|sum[DROP_W+4:DROP_W]) begin
            return '1;
        end
        return sum[DROP_W-1:0];
    endfunction

    prio_popcount16 u_drop_cnt (
        .vec   (drop_vec),
        .count (drop_n)
    );

    // The encoder answer is usable only if it is in range and names a set bit.
    assign code_ok = (bus.enc_code[CODE_W-1:IDX_W] == '0) &&
                     pend_q[bus.enc_code[IDX_W-1:0]];

    assign accept = (state_q == OFFER) && bus.grant_ready;

    // Pending update: new events set, an accepted grant clears; set wins.
    always_comb begin
        set_vec  = bus.ena ? bus.req_in : '0;
        clr_vec  = accept ? ({{(N_REQ-1){1'b0}}, 1'b1} << idx_q) : '0;
        pend_d   = set_vec | (pend_q & ~clr_vec);
        drop_vec = set_vec & pend_q & ~clr_vec;
    end

    // Pending bits and drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            drop_q <= '0;
        end else begin
            pend_q <= pend_d;
            drop_q <= sat_add(drop_q, drop_n);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: wait for work, vet the encoder, hold the offer until taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|pend_q) state_d = SAMPLE;
            SAMPLE:  state_d = code_ok ? OFFER : IDLE;
            OFFER:   if (bus.grant_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the winner, or record an inconsistent encoder answer, while sampling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            err_q <= 1'b0;
        end else if (state_q == SAMPLE) begin
            if (code_ok) begin
                idx_q <= bus.enc_code[IDX_W-1:0];
            end else begin
                err_q <= 1'b1;
            end
        end
    end

    // FSM outputs and status.
    always_comb begin
        bus.grant_valid = (state_q == OFFER);
        bus.busy        = (state_q != IDLE) || (|pend_q);
        bus.grant_idx   = idx_q;
        bus.pend_out    = pend_q;
        bus.drop_count  = drop_q;
        bus.err         = err_q;
    end

endmodule

// File: tb/tb_prio_pending_scheduler.sv
// Directed bench for prio_pending_scheduler with a behavioural priority
// encoder that can be overridden to inject bad codes.
module tb_prio_pending_scheduler;
    import prio_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic enc_force;
    logic [7:0] enc_force_val;
    int n_cmp = 0;
    int n_bad = 0;
    int exp_order [16];

    always #5 clk = ~clk;

    prio_pending_scheduler_if #(.DROP_W(8)) bus ();

    prio_pending_scheduler #(.DROP_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference encoder: highest set bit, or NONE_CODE; optionally overridden.
    always_comb begin
        bus.enc_code = NONE_CODE;
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.pend_out[i]) bus.enc_code = 8'(i);
        end
        if (enc_force) bus.enc_code = enc_force_val;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_req(input logic [15:0] v);
        bus.req_in = v;
        step(1);
        bus.req_in = '0;
    endtask

    initial begin
        rst = 1'b1;
        bus.ena = 1'b1;
        bus.req_in = '0;
        bus.grant_ready = 1'b0;
        enc_force = 1'b0;
        enc_force_val = 8'h00;

        // Power-on reset values
        step(2);
        check_eq("rst_pend", 32'(bus.pend_out), 0);
        check_eq("rst_gv", 32'(bus.grant_valid), 0);
        check_eq("rst_idx", 32'(bus.grant_idx), 0);
        check_eq("rst_drop", 32'(bus.drop_count), 0);
        check_eq("rst_err", 32'(bus.err), 0);
        check_eq("rst_busy", 32'(bus.busy), 0);
        rst = 1'b0;
        step(1);

        // Single event on line 4
        bus.grant_ready = 1'b1;
        pulse_req(16'h0010);
        check_eq("single_pend", 32'(bus.pend_out), 'h0010);
        check_eq("single_busy", 32'(bus.busy), 1);
        check_eq("single_gv_early", 32'(bus.grant_valid), 0);
        step(2);
        check_eq("single_gv", 32'(bus.grant_valid), 1);
        check_eq("single_idx", 32'(bus.grant_idx), 4);
        step(1);
        check_eq("single_clr", 32'(bus.pend_out), 0);
        check_eq("single_gv_off", 32'(bus.grant_valid), 0);
        check_eq("single_drop", 32'(bus.drop_count), 0);
        step(1);
        check_eq("single_idle", 32'(bus.busy), 0);

        // Priority 15 before 0, offer held stable while not ready
        bus.grant_ready = 1'b0;
        pulse_req(16'h8001);
        step(2);
        check_eq("prio_gv", 32'(bus.grant_valid), 1);
        check_eq("prio_idx", 32'(bus.grant_idx), 15);
        for (int k = 0; k < 5; k++) begin
            step(1);
            check_eq("prio_hold_gv", 32'(bus.grant_valid), 1);
            check_eq("prio_hold_idx", 32'(bus.grant_idx), 15);
        end
        bus.grant_ready = 1'b1;
        step(1);
        check_eq("prio_pend_after15", 32'(bus.pend_out), 'h0001);
        check_eq("prio_gv_gap", 32'(bus.grant_valid), 0);
        step(2);
        check_eq("prio_gv2", 32'(bus.grant_valid), 1);
        check_eq("prio_idx2", 32'(bus.grant_idx), 0);
        step(1);
        check_eq("prio_pend_done", 32'(bus.pend_out), 0);
        check_eq("prio_busy_done", 32'(bus.busy), 0);

        // Event on the bit being cleared is kept and is not a drop
        bus.grant_ready = 1'b0;
        pulse_req(16'h0080);
        step(2);
        check_eq("soc_gv", 32'(bus.grant_valid), 1);
        check_eq("soc_idx", 32'(bus.grant_idx), 7);
        bus.grant_ready = 1'b1;
        bus.req_in = 16'h0080;
        step(1);
        bus.req_in = '0;
        check_eq("soc_pend", 32'(bus.pend_out), 'h0080);
        check_eq("soc_drop", 32'(bus.drop_count), 0);
        check_eq("soc_gv_off", 32'(bus.grant_valid), 0);
        step(2);
        check_eq("soc_gv2", 32'(bus.grant_valid), 1);
        check_eq("soc_idx2", 32'(bus.grant_idx), 7);
        step(1);
        check_eq("soc_pend_done", 32'(bus.pend_out), 0);

        // Encoder reports "none" while a bit is pending
        enc_force = 1'b1;
        enc_force_val = 8'hF0;
        pulse_req(16'h0002);
        step(2);
        check_eq("encA_err", 32'(bus.err), 1);
        check_eq("encA_gv", 32'(bus.grant_valid), 0);
        check_eq("encA_busy", 32'(bus.busy), 1);
        for (int k = 0; k < 4; k++) begin
            step(1);
            check_eq("encA_gv_hold", 32'(bus.grant_valid), 0);
            check_eq("encA_err_sticky", 32'(bus.err), 1);
        end
        enc_force = 1'b0;
        step(2);
        check_eq("encA_recover_gv", 32'(bus.grant_valid), 1);
        check_eq("encA_recover_idx", 32'(bus.grant_idx), 1);
        step(1);
        check_eq("encA_recover_pend", 32'(bus.pend_out), 0);
        check_eq("encA_err_kept", 32'(bus.err), 1);

        // Clear the error flag with a reset between clock edges
        #2 rst = 1'b1;
        #1 check_eq("rst2_err", 32'(bus.err), 0);
        @(negedge clk);
        rst = 1'b0;

        // Encoder points at a bit that is not pending
        enc_force = 1'b1;
        enc_force_val = 8'd5;
        pulse_req(16'h0002);
        step(2);
        check_eq("encB_err", 32'(bus.err), 1);
        check_eq("encB_gv", 32'(bus.grant_valid), 0);
        enc_force = 1'b0;
        step(1);
        check_eq("encB_gv_sample", 32'(bus.grant_valid), 0);
        step(1);
        check_eq("encB_recover_gv", 32'(bus.grant_valid), 1);
        check_eq("encB_recover_idx", 32'(bus.grant_idx), 1);
        step(1);
        check_eq("encB_recover_pend", 32'(bus.pend_out), 0);

        // Drops: three cycles of 0x0003 with no acceptance
        bus.grant_ready = 1'b0;
        bus.req_in = 16'h0003;
        step(3);
        check_eq("drop_three", 32'(bus.drop_count), 4);
        bus.ena = 1'b0;
        step(1);
        check_eq("drop_ena_off", 32'(bus.drop_count), 4);
        bus.ena = 1'b1;
        check_eq("drop_gv", 32'(bus.grant_valid), 1);
        check_eq("drop_idx", 32'(bus.grant_idx), 1);

        // Saturation under continuous all-ones; offer is not preempted
        bus.req_in = 16'hFFFF;
        step(10);
        check_eq("sat_mid", 32'(bus.drop_count), 150);
        check_eq("sat_nopreempt_idx", 32'(bus.grant_idx), 1);
        check_eq("sat_pend_all", 32'(bus.pend_out), 'hFFFF);
        step(10);
        check_eq("sat_top", 32'(bus.drop_count), 255);
        step(1);
        check_eq("sat_nowrap", 32'(bus.drop_count), 255);
        bus.req_in = '0;

        // Drain: held grant 1, then 15 down to 2, then 0
        exp_order[0] = 1;
        for (int k = 1; k < 15; k++) exp_order[k] = 16 - k;
        exp_order[15] = 0;
        bus.grant_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            int w;
            w = 0;
            while (!bus.grant_valid && w < 8) begin
                step(1);
                w++;
            end
            check_eq("drain_gv", 32'(bus.grant_valid), 1);
            check_eq("drain_idx", 32'(bus.grant_idx), 32'(exp_order[k]));
            step(1);
        end
        check_eq("drain_pend", 32'(bus.pend_out), 0);
        check_eq("drain_busy", 32'(bus.busy), 0);

        // Asynchronous reset while a grant is on offer
        bus.grant_ready = 1'b0;
        pulse_req(16'h0010);
        step(2);
        check_eq("mid_gv_before", 32'(bus.grant_valid), 1);
        check_eq("mid_idx_before", 32'(bus.grant_idx), 4);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_pend", 32'(bus.pend_out), 0);
        check_eq("mid_rst_gv", 32'(bus.grant_valid), 0);
        check_eq("mid_rst_idx", 32'(bus.grant_idx), 0);
        check_eq("mid_rst_drop", 32'(bus.drop_count), 0);
        check_eq("mid_rst_err", 32'(bus.err), 0);
        check_eq("mid_rst_busy", 32'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.grant_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1);
            check_eq("mid_after_gv", 32'(bus.grant_valid), 0);
            check_eq("mid_after_pend", 32'(bus.pend_out), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prio_pending_scheduler.md
Name: prio_pending_scheduler

Overview:
- Upstream companion to the 16-bit priority encoder. Captures event pulses into 16 sticky pending bits and drives that vector to the encoder.
- Reads back the encoder's 8-bit code, 0..15 for the highest set bit or 8'hF0 for none.
- Offers the winning index on a valid/ready grant port and clears the pending bit once the grant is accepted.
- Serves events strictly by priority, counts events lost to already-pending bits, and flags encoder-code inconsistencies.

Parameters:
- N_REQ, 16, number of request lines. Fixed; encoder width.
- DROP_W, 8, width of the saturating drop counter.
- NONE_CODE, 8'hF0, encoder code meaning "no bit set".

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  when 0, req_in is ignored. The FSM keeps running.
- req_in  in  16  event pulses; bit i set means event on line i this cycle.
- pend_out  out  16  registered pending vector, wired to the encoder input.
- enc_code  in  8  encoder result for pend_out (combinational through the encoder).
- grant_valid  out  1  grant offered.
- grant_ready  in  1  consumer accepts the grant.
- grant_idx  out  4  index being granted; stable while grant_valid=1.
- drop_count  out  DROP_W  saturating count of dropped events.
- err  out  1  sticky encoder-inconsistency flag.
- busy  out  1  1 when state is not IDLE, or when pend_out is nonzero.

Behaviour:
- Reset (async, any time, including mid-grant):
  - pend_out=0, grant_valid=0, grant_idx=0, drop_count=0, err=0, state=IDLE.
- Pending register, per bit i, every edge:
  - next = set_i | (pend_i & ~clr_i).
  - set_i = ena & req_in[i].
  - clr_i = grant accepted this edge (grant_valid & grant_ready) and grant_idx==i.
  - Set wins over clear: an event on the bit being cleared is retained and is not a drop.
- Drop counting:
  - A drop is set_i & pend_i & ~clr_i.
  - drop_count += popcount(drops), saturating at 2^DROP_W-1. It never wraps.
- FSM states: IDLE, SAMPLE, OFFER.
  - IDLE: if pend_out!=0, go to SAMPLE. grant_valid=0.
  - SAMPLE: check enc_code.
    - Valid when enc_code<16 and pend_out[enc_code]==1: grant_idx<=enc_code[3:0], go to OFFER.
    - enc_code==NONE_CODE while pend_out!=0, out-of-range code, or code pointing at a clear bit: err<=1, go to IDLE, no grant.
  - OFFER: grant_valid=1, grant_idx held.
    - On grant_ready=1: handshake completes on that edge, the bit clears, go to IDLE.
    - grant_valid never deasserts without a handshake.
- Latency:
  - req sampled at edge E: pend_out visible after E, SAMPLE after E+1, grant_valid=1 after E+2.
  - With grant_ready=1, accept at E+3; the bit is clear after E+3.
  - Peak throughput is one grant per 3 cycles.
- Priority: the grant index is the encoder's choice as sampled in SAMPLE. Higher-index requests that arrive during OFFER do not preempt.
- ena=0: no new pending bits are set and no drops are counted. Grants and clears proceed.
- All-16 pending: served 15 down to 0, one per grant.

Decomposition:
- Shared package prio_pkg:
  - constants N_REQ=16, IDX_W=4, CODE_W=8, NONE_CODE=8'hF0.
  - enumerated FSM state type {IDLE, SAMPLE, OFFER}.
  - used by the encoder and by this block.
- One sub-module: prio_popcount16, a combinational 16-bit to 5-bit population count for drop accounting.

Test Plan:
- Reset mid-OFFER: pend=0x0010 with grant_valid=1, assert rst -> outputs 0 immediately, state IDLE, and no grant after release.
- Single event: req_in=0x0010 pulse at edge E, grant_ready=1 -> grant_valid=1 after E+2 with grant_idx=4; pend_out=0 after E+3; drop_count=0.
- Priority order: req_in=0x8001 in one cycle, grant_ready=1 -> grant_idx=15 first, then 0, then busy=0. With grant_ready held 0 for 5 cycles, grant_valid and grant_idx=15 stay stable.
- Drops and saturation:
  - req_in=0x0003 on three consecutive cycles, no grant accepted -> drop_count=4.
  - Continuous 0xFFFF for 20 cycles -> drop_count saturates at 255.
- Set-over-clear: during the accepting edge of grant_idx=7, req_in=0x0080 -> bit 7 remains set, drop_count unchanged, and a second grant of 7 follows.
- Encoder fault: force enc_code=8'hF0 while pend_out=0x0002, and separately enc_code=5 while pend_out[5]=0 -> err=1 and sticky, no grant issued, FSM returns to IDLE.
